// File: rtl/alu_result_framer_if.sv
// Handshake bundle between the ALU result FIFO, the framer and the host link.
// Valid/ready: a word moves on a rising clk edge where valid && ready are both high;
// once valid is raised, data (and last) hold stable until that transfer completes.
interface alu_result_framer_if;
  logic [8:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/alu_result_framer.sv
// Collects 9-bit ALU results into frames of up to FRAME_LEN and streams them out as
// header / payload / checksum-trailer 16-bit words; partial frames flush after TIMEOUT idle edges.
module alu_result_framer #(
  parameter int FRAME_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_framer_if.slave    bus,
  output logic [7:0]            frame_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_t;

  localparam logic [3:0] FRAME_LEN_W  = 4'(FRAME_LEN);
  localparam logic [3:0] FRAME_LEN_M1 = 4'(FRAME_LEN - 1);
  localparam logic [7:0] TIMEOUT_M1   = 8'(TIMEOUT - 1);
  localparam logic [7:0] HDR_MAGIC    = 8'hA5;

  state_t      state;
  logic [3:0]  wr_idx;
  logic [3:0]  rd_idx;
  logic [3:0]  count;
  logic [7:0]  idle_cnt;
  logic [3:0]  seq;
  logic [15:0] checksum;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [15:0] out_data_q;

  // Sized to the full 4-bit index range so wr_idx/rd_idx index it directly.
  logic [8:0]  data_buf [16];

  logic in_xfer;
  logic out_xfer;

  assign in_xfer       = bus.in_valid && in_ready_q;
  assign out_xfer      = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state;

  // Buffer contents need no reset: wr_idx/count gate what is ever read out.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      data_buf[wr_idx] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      wr_idx      <= 4'd0;
      rd_idx      <= 4'd0;
      count       <= 4'd0;
      idle_cnt    <= 8'd0;
      seq         <= 4'd0;
      checksum    <= 16'd0;
      frame_cnt   <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 16'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_xfer) begin
            checksum <= checksum + {7'd0, bus.in_data};
            wr_idx   <= wr_idx + 4'd1;
            idle_cnt <= 8'd0;
            if (wr_idx == FRAME_LEN_M1) begin
              state       <= HEADER;
              count       <= FRAME_LEN_W;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= {HDR_MAGIC, seq, FRAME_LEN_W};
            end
          end else if (wr_idx != 4'd0) begin
            // The edge that would make the idle count reach TIMEOUT starts the flush.
            if (idle_cnt == TIMEOUT_M1) begin
              state       <= HEADER;
              count       <= wr_idx;
              idle_cnt    <= 8'd0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= {HDR_MAGIC, seq, wr_idx};
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end

        HEADER: begin
          if (out_xfer) begin
            state      <= PAYLOAD;
            rd_idx     <= 4'd0;
            out_data_q <= {7'd0, data_buf[4'd0]};
          end
        end

        PAYLOAD: begin
          if (out_xfer) begin
            if (rd_idx == count - 4'd1) begin
              state      <= TRAILER;
              out_data_q <= checksum;
              out_last_q <= 1'b1;
            end else begin
              rd_idx     <= rd_idx + 4'd1;
              out_data_q <= {7'd0, data_buf[rd_idx + 4'd1]};
            end
          end
        end

        TRAILER: begin
          if (out_xfer) begin
            state       <= COLLECT;
            seq         <= seq + 4'd1;
            frame_cnt   <= frame_cnt + 8'd1;
            checksum    <= 16'd0;
            wr_idx      <= 4'd0;
            idle_cnt    <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 16'd0;
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_framer.sv
// Directed bench for alu_result_framer: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares every output transfer.
module tb_alu_result_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] frame_cnt;
  logic [1:0] dbg_state;

  alu_result_framer_if bus();

  alu_result_framer #(.FRAME_LEN(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a word seen valid && ready at negedge transfers on the next rising edge.
  always @(negedge clk) begin
    if (reset && bus.out_valid) begin
      chk("in_ready_during_output", 32'(bus.in_ready), 32'd0);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected no word",
                   bus.out_data, bus.out_last);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_word", {15'd0, bus.out_last, bus.out_data}, {15'd0, mon_e});
        end
      end
    end
  end

  task automatic send(input logic [8:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: in_ready=%0b expected 1 within 300 cycles", bus.in_ready);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic full_frame(input logic [8:0] d0, input logic [8:0] d1,
                            input logic [8:0] d2, input logic [8:0] d3,
                            input logic [3:0] s);
    logic [15:0] sum;
    sum = 16'(d0) + 16'(d1) + 16'(d2) + 16'(d3);
    exp_q.push_back({1'b0, 8'hA5, s, 4'd4});
    exp_q.push_back({1'b0, 7'd0, d0});
    exp_q.push_back({1'b0, 7'd0, d1});
    exp_q.push_back({1'b0, 7'd0, d2});
    exp_q.push_back({1'b0, 7'd0, d3});
    exp_q.push_back({1'b1, sum});
    send(d0);
    send(d1);
    send(d2);
    send(d3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 9'($urandom_range(0, 511));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt),     32'd0);
    end
    exp_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_out_last",  32'(bus.out_last),  32'd0);
    chk("post_rst_frame_cnt", 32'(frame_cnt),     32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input logic [15:0] w, input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid && bus.out_data == w) return;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected 0x%0h presented", name, bus.out_data, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 9'd0;
    bus.out_ready = 1'b1;
    do_reset();

    // Full frame, no backpressure
    full_frame(9'h003, 9'h005, 9'h1FF, 9'h000, 4'd0);
    chk("valid_after_last_accept", 32'(bus.out_valid), 32'd1);
    chk("ready_low_after_last",    32'(bus.in_ready),  32'd0);
    chk("header_word_first",       32'(bus.out_data),  32'h0000A504);
    drain();
    chk("frame_cnt_1", 32'(frame_cnt), 32'd1);

    // Backpressure while 0x0005 is presented
    full_frame(9'h003, 9'h005, 9'h1FF, 9'h000, 4'd1);
    wait_word(16'h0005, "bp_reach_word");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 9'h111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'h5);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

    // Timeout flush of a partial frame
    do_reset();
    exp_q.push_back(17'h0A502);
    exp_q.push_back(17'h0000A);
    exp_q.push_back(17'h00014);
    exp_q.push_back(17'h1001E);
    send(9'h00A);
    send(9'h014);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk((i < 16) ? "no_early_flush" : "flush_at_timeout",
          32'(bus.out_valid), 32'(i == 16));
    end
    drain();
    chk("frame_cnt_timeout", 32'(frame_cnt), 32'd1);

    // Accept on the timeout edge wins over the flush
    exp_q.push_back(17'h0A514);
    exp_q.push_back(17'h00001);
    exp_q.push_back(17'h00002);
    exp_q.push_back(17'h00003);
    exp_q.push_back(17'h00004);
    exp_q.push_back(17'h1000A);
    send(9'h001);
    send(9'h002);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    send(9'h003);
    chk("no_flush_on_accept", 32'(bus.out_valid), 32'd0);
    chk("ready_after_race",   32'(bus.in_ready),  32'd1);
    send(9'h004);
    drain();
    chk("frame_cnt_race", 32'(frame_cnt), 32'd2);

    // Sequence field wraps 15 -> 0
    do_reset();
    for (int f = 0; f < 17; f++) begin
      full_frame(9'(f * 7 + 1), 9'(f * 7 + 4), 9'(f * 7 + 7), 9'(f * 7 + 10), 4'(f));
    end
    drain();
    chk("frame_cnt_17", 32'(frame_cnt), 32'd17);

    // frame_cnt wraps 255 -> 0
    do_reset();
    for (int f = 0; f < 255; f++) begin
      full_frame(9'(f), 9'(f + 1), 9'(f + 2), 9'(f + 3), 4'(f));
    end
    drain();
    chk("frame_cnt_255", 32'(frame_cnt), 32'd255);
    full_frame(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 4'd15);
    drain();
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Reset while the second payload word is presented
    do_reset();
    full_frame(9'h011, 9'h022, 9'h033, 9'h044, 4'd0);
    wait_word(16'h0022, "mid_reach_word");
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    full_frame(9'h100, 9'h001, 9'h002, 9'h003, 4'd0);
    drain();
    chk("frame_cnt_after_mid_rst", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
